// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Optional build macro: INSTR_FETCH_BYTE_ADDR_EN (byte-addressed PC).
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W    = 32;
    localparam int unsigned FETCH_DATA_W    = 32;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;
    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam int unsigned FETCH_CNT_W     = 2;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Decode-side valid/ready handshake of the instruction fetch front end.
// Optional build macro: INSTR_FETCH_BYTE_ADDR_EN (out_pc is a byte address).
interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
);
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;

    modport master (output out_valid, output out_instr, output out_pc, input out_ready);
    modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_buf.sv
// 2-entry synchronous FIFO of {pc, instr} with flush and a registered head.
// Optional build macro: INSTR_FETCH_BYTE_ADDR_EN (no effect in this block).
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [ADDR_W-1:0]      push_pc,
    input  logic [DATA_W-1:0]      push_instr,
    input  logic                   pop,
    output logic [FETCH_CNT_W-1:0] count,
    output logic                   head_valid,
    output logic [ADDR_W-1:0]      head_pc,
    output logic [DATA_W-1:0]      head_instr
);
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t                 ent0, ent1, ent0_nxt, ent1_nxt, push_e;
    logic [FETCH_CNT_W-1:0] cnt_nxt;
    logic                   pop_i;

    assign push_e     = '{pc: push_pc, instr: push_instr};
    assign pop_i      = pop & head_valid;
    assign head_pc    = ent0.pc;
    assign head_instr = ent0.instr;

    // Next FIFO contents: ent0 is always the head, ent1 the second entry.
    always_comb begin
        cnt_nxt  = count;
        ent0_nxt = ent0;
        ent1_nxt = ent1;
        if (flush) begin
            cnt_nxt = '0;
        end else begin
            case ({push, pop_i})
                2'b10: begin
                    if (count == '0) ent0_nxt = push_e;
                    else             ent1_nxt = push_e;
                    cnt_nxt = count + 2'd1;
                end
                2'b01: begin
                    ent0_nxt = ent1;
                    cnt_nxt  = count - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the push lands behind whatever remains.
                    if (count == 2'd1) begin
                        ent0_nxt = push_e;
                    end else begin
                        ent0_nxt = ent1;
                        ent1_nxt = push_e;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO state registers, head valid registered alongside the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0       <= '0;
            ent1       <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            ent0       <= ent0_nxt;
            ent1       <= ent1_nxt;
            count      <= cnt_nxt;
            head_valid <= (cnt_nxt != '0);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, credit-based issue and 2-entry return buffer.
// Optional build macro: INSTR_FETCH_BYTE_ADDR_EN (byte PC, imem_addr = fetch_pc >> 2).
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    instr_fetch_if.master     dec
);
`ifdef INSTR_FETCH_BYTE_ADDR_EN
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
`else
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);
`endif

    logic [ADDR_W-1:0]      fetch_pc, inflight_pc, redirect_tgt;
    logic                   inflight, issue, pop, push;
    logic [FETCH_CNT_W-1:0] count;
    logic [2:0]             occ;
    logic                   head_valid;
    logic [ADDR_W-1:0]      head_pc;
    logic [DATA_W-1:0]      head_instr;

`ifdef INSTR_FETCH_BYTE_ADDR_EN
    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
    assign imem_addr    = fetch_pc >> 2;
`else
    assign redirect_tgt = redirect_pc;
    assign imem_addr    = fetch_pc;
`endif

    assign pop  = head_valid & dec.out_ready;
    assign push = inflight & ~redirect_valid;
    assign occ  = {1'b0, count} + {2'b00, inflight};

    // Issue only when buffered plus in-flight entries, net of this pop, leave a free slot.
    always_comb begin
        issue = 1'b0;
        if (!redirect_valid && (occ < 3'(FETCH_BUF_DEPTH) + {2'b00, pop}))
            issue = 1'b1;
    end

    // PC and in-flight request tracking; redirect overrides issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + PC_STEP;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (inflight_pc),
        .push_instr (imem_data),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_pc    (head_pc),
        .head_instr (head_instr)
    );

    assign dec.out_valid = head_valid;
    assign dec.out_pc    = head_pc;
    assign dec.out_instr = head_instr;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stream, backpressure, redirects, async reset.
// Optional build macro: INSTR_FETCH_BYTE_ADDR_EN (byte-address expectations).
module tb_instr_fetch;
    import fetch_pkg::*;

`ifdef INSTR_FETCH_BYTE_ADDR_EN
    localparam int unsigned STEP      = 4;
    localparam logic [31:0] RPC2_IN   = 32'h103;
    localparam int unsigned RPC2_WORD = 32'h40;
`else
    localparam int unsigned STEP      = 1;
    localparam logic [31:0] RPC2_IN   = 32'h80;
    localparam int unsigned RPC2_WORD = 32'h80;
`endif
    localparam int unsigned W1 = 32'h40;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;
    int n_popped = 0;

    fetch_entry_t sb[$];

    instr_fetch_if #(.ADDR_W(32), .DATA_W(32)) dec ();

    instr_fetch #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: mem[i] = 32'h1000_0000 + i, one-cycle registered read.
    always @(posedge clk) imem_data <= 32'h1000_0000 + imem_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input int unsigned word, input int unsigned n);
        fetch_entry_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.pc    = 32'((word + i) * STEP);
            e.instr = 32'h1000_0000 + 32'(word + i);
            sb.push_back(e);
        end
    endtask

    // Monitor: every accepted instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && dec.out_valid && dec.out_ready) begin
            fetch_entry_t e;
            n_checks++;
            n_popped++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc %h instr %h expected none", dec.out_pc, dec.out_instr);
            end else begin
                e = sb.pop_front();
                if (dec.out_pc !== e.pc || dec.out_instr !== e.instr) begin
                    n_fail++;
                    $display("FAIL sb_order: got pc %h instr %h expected pc %h instr %h",
                             dec.out_pc, dec.out_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr",  imem_addr,     32'h0);
        chk("rst_valid", 32'(dec.out_valid), 32'h0);
        chk("rst_instr", dec.out_instr, 32'h0);
        chk("rst_pc",    dec.out_pc,    32'h0);

        push_seq(0, 40);
        rst_n = 1'b1;
        for (int c = 0; c < 34; c++) begin
            dec.out_ready  = !((c >= 4 && c <= 7) || (c >= 21 && c <= 25));
            redirect_valid = (c == 10) || (c == 25);
            redirect_pc    = (c == 10) ? 32'(W1 * STEP) : ((c == 25) ? RPC2_IN : 32'h0);
            if (c == 11) begin
                sb.delete();
                push_seq(W1, 40);
            end
            if (c == 26) begin
                sb.delete();
                push_seq(RPC2_WORD, 40);
            end
            @(negedge clk);
            if (c <= 1)                chk("startup_idle", 32'(dec.out_valid), 32'h0);
            if (c <= 1)                chk("startup_addr", imem_addr, 32'(c));
            if (c == 2)                chk("first_pc", dec.out_pc, 32'h0);
            if (c == 2 || c == 3)      chk("stream_valid", 32'(dec.out_valid), 32'h1);
            if (c >= 5 && c <= 7)      chk("bp_addr_hold", imem_addr, 32'h4);
            if (c >= 5 && c <= 7)      chk("bp_head_hold", dec.out_pc, 32'(2 * STEP));
            if (c == 11 || c == 12)    chk("redir_bubble", 32'(dec.out_valid), 32'h0);
            if (c == 11)               chk("redir_addr", imem_addr, 32'(W1));
            if (c >= 13 && c <= 20)    chk("redir_stream_valid", 32'(dec.out_valid), 32'h1);
            if (c == 13)               chk("redir_first_pc", dec.out_pc, 32'(W1 * STEP));
            if (c >= 22 && c <= 25)    chk("full_addr_hold", imem_addr, 32'(W1 + 10));
            if (c >= 22 && c <= 25)    chk("full_head_hold", dec.out_pc, 32'((W1 + 8) * STEP));
            if (c == 26 || c == 27)    chk("flush_bubble", 32'(dec.out_valid), 32'h0);
            if (c == 26)               chk("flush_addr", imem_addr, 32'(RPC2_WORD));
            if (c == 28)               chk("flush_first_pc", dec.out_pc, 32'(RPC2_WORD * STEP));
            if (c >= 28)               chk("flush_stream_valid", 32'(dec.out_valid), 32'h1);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-cycle: outputs clear before the next edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(dec.out_valid), 32'h0);
        chk("async_pc",    dec.out_pc,    32'h0);
        chk("async_instr", dec.out_instr, 32'h0);
        chk("async_addr",  imem_addr,     32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        push_seq(0, 40);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            dec.out_ready = 1'b1;
            @(negedge clk);
            if (c <= 1) chk("restart_idle", 32'(dec.out_valid), 32'h0);
            if (c == 2) chk("restart_pc", dec.out_pc, 32'h0);
            if (c >= 2) chk("restart_valid", 32'(dec.out_valid), 32'h1);
            @(posedge clk);
            #1;
        end

        chk("delivered_total", 32'(n_popped), 32'd27);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
